// File: rtl/wb_pkg.sv
// Writeback-stage shared definitions.
// Bus layout and WB-field encodings, shared with the memory stage.
package wb_pkg;

  localparam int XLEN = 16;
  localparam int RAW  = 3;
  localparam int BUSW = 3 * XLEN + 3;

  localparam int WB_HI  = 50;
  localparam int WB_LO  = 48;
  localparam int IMM_HI = 47;
  localparam int IMM_LO = 32;
  localparam int ALU_HI = 31;
  localparam int ALU_LO = 16;
  localparam int MEM_HI = 15;
  localparam int MEM_LO = 0;

  localparam int WB_REG_WRITE = 2;
  localparam int WB_SRC_HI    = 1;
  localparam int WB_SRC_LO    = 0;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_IMM  = 2'b10,
    SRC_RSVD = 2'b11
  } src_e;

  // Sources whose value exists while still in stage 1.
  function automatic logic fwd_ok(input logic [1:0] src);
    return (src == SRC_ALU) || (src == SRC_IMM);
  endfunction

endpackage

// File: rtl/wb_select.sv
// Writeback source mux and write qualification.
// Reserved source yields zero data and no write.
module wb_select
  import wb_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         valid,
  input  logic         reg_write,
  input  logic [1:0]   src,
  input  logic [W-1:0] alu,
  input  logic [W-1:0] mem,
  input  logic [W-1:0] imm,
  output logic         we,
  output logic [W-1:0] data
);

  // Pick the writeback word by source encoding.
  always_comb begin
    data = '0;
    unique case (1'b1)
      (src == SRC_ALU): data = alu;
      (src == SRC_MEM): data = mem;
      (src == SRC_IMM): data = imm;
      default:          data = '0;
    endcase
  end

  assign we = valid & reg_write & (src != SRC_RSVD);

endmodule

// File: rtl/writeback_stage.sv
// Two-entry writeback pipeline with mem-word realignment.
// Drives the register-file write port, forwarding taps and retire count.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int RA = RAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3*W+2:0] data_in,
  input  logic [RA-1:0]  rd_in,
  input  logic           in_valid,
  input  logic           stall,
  input  logic           flush,
  output logic           rf_we,
  output logic [RA-1:0]  rf_waddr,
  output logic [W-1:0]   rf_wdata,
  output logic           fwd1_valid,
  output logic [RA-1:0]  fwd1_addr,
  output logic [W-1:0]   fwd1_data,
  output logic           fwd2_valid,
  output logic [RA-1:0]  fwd2_addr,
  output logic [W-1:0]   fwd2_data,
  output logic [15:0]    retired
);

  logic          s1_valid;
  logic          s1_rw;
  logic [1:0]    s1_src;
  logic [RA-1:0] s1_rd;
  logic [W-1:0]  s1_imm;
  logic [W-1:0]  s1_alu;

  logic          s2_valid;
  logic          s2_we;
  logic [RA-1:0] s2_rd;
  logic [W-1:0]  s2_data;
  logic [15:0]   ret_q;

  logic          sel_we;
  logic [W-1:0]  sel_data;

  // The mem word is taken live: it belongs to the s1 entry.
  wb_select #(.W(W)) u_sel (
    .valid     (s1_valid),
    .reg_write (s1_rw),
    .src       (s1_src),
    .alu       (s1_alu),
    .mem       (data_in[MEM_HI:MEM_LO]),
    .imm       (s1_imm),
    .we        (sel_we),
    .data      (sel_data)
  );

  // Stage 1: capture the early bus fields unless stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rw    <= 1'b0;
      s1_src   <= SRC_ALU;
      s1_rd    <= '0;
      s1_imm   <= '0;
      s1_alu   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_rw    <= data_in[WB_LO+WB_REG_WRITE];
      s1_src   <= data_in[WB_LO+WB_SRC_HI:WB_LO+WB_SRC_LO];
      s1_rd    <= rd_in;
      s1_imm   <= data_in[IMM_HI:IMM_LO];
      s1_alu   <= data_in[ALU_HI:ALU_LO];
    end else if (flush) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: advance s1 or insert a bubble on stall/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_we    <= 1'b0;
      s2_rd    <= '0;
      s2_data  <= '0;
    end else if (stall) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid & ~flush;
      s2_we    <= sel_we;
      s2_rd    <= s1_rd;
      s2_data  <= sel_data;
    end
  end

  // Count every instruction leaving stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= '0;
    end else if (s2_valid) begin
      ret_q <= ret_q + 16'd1;
    end
  end

  assign rf_we    = s2_valid & s2_we;
  assign rf_waddr = s2_rd;
  assign rf_wdata = s2_data;

  assign fwd2_valid = rf_we;
  assign fwd2_addr  = rf_waddr;
  assign fwd2_data  = rf_wdata;

  assign fwd1_valid = s1_valid & s1_rw & fwd_ok(s1_src);
  assign fwd1_addr  = s1_rd;
  assign fwd1_data  = (s1_src == SRC_IMM) ? s1_imm : s1_alu;

  assign retired = ret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage.
// Instruction-level reference model plus literal anchors.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic        st = 1'b0;
  logic        fl = 1'b0;
  logic [2:0]  wbv = 3'b000;
  logic [15:0] immv = 16'h0;
  logic [15:0] aluv = 16'h0;
  logic [15:0] memv = 16'h0;
  logic [2:0]  rdv = 3'd0;
  logic [50:0] data_in;

  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        fwd1_valid;
  logic [2:0]  fwd1_addr;
  logic [15:0] fwd1_data;
  logic        fwd2_valid;
  logic [2:0]  fwd2_addr;
  logic [15:0] fwd2_data;
  logic [15:0] retired;

  int n_chk = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  assign data_in = {wbv, immv, aluv, memv};

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .rd_in      (rdv),
    .in_valid   (iv),
    .stall      (st),
    .flush      (fl),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd1_valid (fwd1_valid),
    .fwd1_addr  (fwd1_addr),
    .fwd1_data  (fwd1_data),
    .fwd2_valid (fwd2_valid),
    .fwd2_addr  (fwd2_addr),
    .fwd2_data  (fwd2_data),
    .retired    (retired)
  );

  // Reference: one pending instruction awaiting its mem word,
  // and the write it produced (if any) on the last edge.
  logic        m_pv = 1'b0;
  logic [2:0]  m_pwb = 3'b0;
  logic [2:0]  m_prd = 3'd0;
  logic [15:0] m_pimm = 16'h0;
  logic [15:0] m_palu = 16'h0;
  logic        m_out = 1'b0;
  logic        m_we = 1'b0;
  logic [2:0]  m_addr = 3'd0;
  logic [15:0] m_data = 16'h0;
  logic [15:0] m_ret = 16'h0;

  function automatic logic [15:0] pick(input logic [1:0] s,
                                       input logic [15:0] a,
                                       input logic [15:0] m,
                                       input logic [15:0] i);
    case (s)
      2'd0:    return a;
      2'd1:    return m;
      2'd2:    return i;
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pv   <= 1'b0;
      m_out  <= 1'b0;
      m_we   <= 1'b0;
      m_ret  <= 16'h0;
    end else begin
      m_ret <= m_ret + {15'd0, m_out};
      if (!st) begin
        m_out  <= m_pv && !fl;
        m_we   <= m_pv && !fl && m_pwb[2] && (m_pwb[1:0] != 2'b11);
        m_addr <= m_prd;
        m_data <= pick(m_pwb[1:0], m_palu, memv, m_pimm);
        m_pv   <= iv;
        m_pwb  <= wbv;
        m_prd  <= rdv;
        m_pimm <= immv;
        m_palu <= aluv;
      end else begin
        m_out <= 1'b0;
        m_we  <= 1'b0;
        if (fl) m_pv <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic f1v;
      f1v = m_pv && m_pwb[2] &&
            (m_pwb[1:0] == 2'b00 || m_pwb[1:0] == 2'b10);
      chk("m_rf_we", {31'd0, rf_we}, {31'd0, m_we});
      chk("m_fwd2_valid", {31'd0, fwd2_valid}, {31'd0, m_we});
      chk("m_fwd1_valid", {31'd0, fwd1_valid}, {31'd0, f1v});
      chk("m_retired", {16'd0, retired}, {16'd0, m_ret});
      if (m_we) begin
        chk("m_rf_waddr", {29'd0, rf_waddr}, {29'd0, m_addr});
        chk("m_rf_wdata", {16'd0, rf_wdata}, {16'd0, m_data});
        chk("m_fwd2_addr", {29'd0, fwd2_addr}, {29'd0, m_addr});
        chk("m_fwd2_data", {16'd0, fwd2_data}, {16'd0, m_data});
      end
      if (f1v) begin
        chk("m_fwd1_addr", {29'd0, fwd1_addr}, {29'd0, m_prd});
        chk("m_fwd1_data", {16'd0, fwd1_data},
            {16'd0, (m_pwb[1:0] == 2'b10) ? m_pimm : m_palu});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] wb,
                     input logic [15:0] imm, input logic [15:0] alu,
                     input logic [2:0] rd);
    iv   = v;
    wbv  = wb;
    immv = imm;
    aluv = alu;
    rdv  = rd;
  endtask

  task automatic idle();
    put(1'b0, 3'b000, 16'h0, 16'h0, 3'd0);
  endtask

  initial begin
    // Reset then idle.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("rst_fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
    chk("rst_fwd2_valid", {31'd0, fwd2_valid}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    tick();
    chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
    chk("idle_retired", {16'd0, retired}, 32'd0);

    // ALU write, latency 2.
    put(1'b1, 3'b100, 16'h5555, 16'h1234, 3'd5);
    tick();
    idle();
    chk("alu_fwd1_valid", {31'd0, fwd1_valid}, 32'd1);
    chk("alu_fwd1_data", {16'd0, fwd1_data}, 32'h1234);
    tick();
    chk("alu_rf_we", {31'd0, rf_we}, 32'd1);
    chk("alu_waddr", {29'd0, rf_waddr}, 32'd5);
    chk("alu_wdata", {16'd0, rf_wdata}, 32'h1234);

    // MEM word arrives one cycle late.
    memv = 16'h0000;
    put(1'b1, 3'b101, 16'h1111, 16'h2222, 3'd2);
    tick();
    idle();
    memv = 16'hBEEF;
    chk("mem_fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
    tick();
    chk("mem_rf_we", {31'd0, rf_we}, 32'd1);
    chk("mem_waddr", {29'd0, rf_waddr}, 32'd2);
    chk("mem_wdata", {16'd0, rf_wdata}, 32'hBEEF);
    tick();
    tick();
    chk("two_retired", {16'd0, retired}, 32'd2);

    // Stall holds the load; exactly one write.
    memv = 16'h0000;
    put(1'b1, 3'b101, 16'h0, 16'h0, 3'd3);
    tick();
    idle();
    st = 1'b1;
    memv = 16'hCAFE;
    tick();
    chk("stall_we_n2", {31'd0, rf_we}, 32'd0);
    tick();
    chk("stall_we_n3", {31'd0, rf_we}, 32'd0);
    st = 1'b0;
    tick();
    chk("stall_we_n4", {31'd0, rf_we}, 32'd1);
    chk("stall_wdata", {16'd0, rf_wdata}, 32'hCAFE);
    chk("stall_waddr", {29'd0, rf_waddr}, 32'd3);
    tick();
    chk("stall_we_after", {31'd0, rf_we}, 32'd0);
    tick();
    chk("stall_retired", {16'd0, retired}, 32'd3);

    // Flushed entry neither writes nor retires.
    put(1'b1, 3'b100, 16'h0, 16'h7777, 3'd6);
    tick();
    idle();
    fl = 1'b1;
    tick();
    fl = 1'b0;
    chk("flush_we", {31'd0, rf_we}, 32'd0);
    tick();
    tick();
    chk("flush_retired", {16'd0, retired}, 32'd3);

    // Reserved source retires without writing.
    put(1'b1, 3'b111, 16'h0, 16'h9999, 3'd7);
    tick();
    idle();
    chk("rsvd_fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
    tick();
    chk("rsvd_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("rsvd_retired", {16'd0, retired}, 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 10);
      put($urandom_range(0, 99) < 75, 3'($urandom_range(0, 7)),
          16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
      if (!st) memv = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    st = 1'b0;
    fl = 1'b0;
    idle();

    // Retire counter wraps after 65536 instructions.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    put(1'b1, 3'b000, 16'h0, 16'h0, 3'd1);
    repeat (65535) tick();
    idle();
    tick();
    tick();
    chk("wrap_full", {16'd0, retired}, 32'h0000FFFF);
    put(1'b1, 3'b000, 16'h0, 16'h0, 3'd1);
    tick();
    idle();
    tick();
    tick();
    chk("wrap_zero", {16'd0, retired}, 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage, directly downstream of the memory stage. Consumes the memory stage's 51-bit result bus and realigns the synchronous-read memory word, which arrives one cycle after its companion fields. Selects the writeback value and drives the register-file write port. Also exposes forwarding taps and a retired-instruction counter.

## Interface
- `W`, 16: datapath word width.
- `RA`, 3: register-address width (8 GPRs).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `data_in`  in  3*W+3: `[50:48]` WB control, `[47:32]` Imm, `[31:16]` ALU, `[15:0]` mem read data.
- `rd_in`  in  RA: destination register, aligned with `data_in[50:16]`.
- `in_valid`  in  1: `data_in[50:16]` / `rd_in` carry a real instruction this cycle.
- `stall`  in  1: hold stage 1; stage 2 receives a bubble.
- `flush`  in  1: kill the stage-1 entry.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  RA: write address.
- `rf_wdata`  out  W: write data.
- `fwd1_valid`, `fwd1_addr`, `fwd1_data`  out  1/RA/W: forwarding tap from stage 1. Asserted only for non-memory sources.
- `fwd2_valid`, `fwd2_addr`, `fwd2_data`  out  1/RA/W: forwarding tap from stage 2; mirrors the `rf_*` outputs.
- `retired`  out  16: count of instructions leaving stage 2.

## Operation
- WB field:
  - bit 2 is `reg_write`.
  - bits 1:0 are `src`: 00 ALU, 01 MEM, 10 IMM, 11 reserved.
  - `src`=11 is treated as `reg_write`=0; the instruction still retires.
- Stage 1 (s1) holds valid, `reg_write`, `src`, `rd`, Imm, ALU.
  - It captures `data_in[50:16]`, `rd_in` and `in_valid` on every edge where `stall`=0.
- Memory alignment: `data_in[15:0]` belongs to the s1 entry. It is sampled at the edge where s1 moves to s2, not when s1 is loaded.
- Upstream contract: while `stall`=1, `data_in[15:0]` holds the value for the current s1 entry.
- Stage 2 (s2) holds valid, `we`, `rd`, and the selected word. On an edge with `stall`=0:
  - s2.valid ← s1.valid & ~`flush`
  - s2.we ← s1.valid & `reg_write` & (`src`≠11)
  - s2.data ← mux(`src`)
- While `stall`=1: s1 holds and s2.valid ← 0 (bubble). A stall never produces a duplicate write.
- `flush` (with `stall`=0) loads a bubble into s2 and lets s1 capture the new input normally. If `flush` and `stall` are both 1, s1.valid is cleared and s1 holds its other fields; `flush` wins.
- Output mapping:
  - `rf_we` = s2.valid & s2.we.
  - `rf_waddr` = s2.rd; `rf_wdata` = s2.data.
  - `fwd2_*` mirror these.
- `fwd1_valid` = s1.valid & `reg_write` & (`src`∈{00,10}). `fwd1_data` is ALU or Imm accordingly.
- `retired` increments by 1 on each edge where s2.valid=1. It wraps from 16'hFFFF to 0.

## Timing
- Instruction presented with `in_valid` at cycle N, no stall: its mem word is sampled at cycle N+1. `rf_we` is high in cycle N+2, and the register file writes at the end of N+2. Latency is 2.
- Full throughput: one instruction per cycle, back-to-back.
- Reset at any edge clears s1.valid, s2.valid, s2.we and `retired`. It also drives `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, and both `fwd*_valid`=0. Reset overrides `stall` and `flush`.
- Reset mid-operation discards both in-flight entries; no write is issued.
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to `rf_*`.

## Structure
- Shared package `wb_pkg`:
  - WB bit positions.
  - `src` encodings `SRC_ALU`/`SRC_MEM`/`SRC_IMM`/`SRC_RSVD`.
  - Bus field bounds (Imm 47:32, ALU 31:16, MEM 15:0, WB 50:48).
  - These are shared with the memory stage.
- One natural sub-module, `wb_select`: a combinational 4-way source mux plus write-qualify. Everything else lives in `writeback_stage`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles → all outputs 0 and `retired`=0. They stay 0 with `in_valid`=0.
- ALU write: `in_valid`=1, WB=3'b100, ALU=16'h1234, `rd_in`=5 at cycle N → `rf_we`=1, `rf_waddr`=5, `rf_wdata`=16'h1234 at N+2. `fwd1_valid`=1 at N+1.
- MEM write alignment: WB=3'b101, `rd_in`=2 at N; `data_in[15:0]`=16'hBEEF at N+1 and 16'h0000 at N → `rf_wdata`=16'hBEEF at N+2. `fwd1_valid`=0 at N+1.
- Stall hold: MEM load at N, `stall`=1 during N+1..N+2, `data_in[15:0]`=16'hCAFE held → `rf_we`=0 during N+2..N+3. One write of 16'hCAFE at N+4, and `retired` increments exactly once.
- Flush and reserved: flush the s1 entry (WB=3'b100) → no write and no retire. WB=3'b111 → no write, `retired` increments.
- Counter wrap: preload 65535 retirements (or force) then retire one more → `retired`=0.
